// File: rtl/fft_out_buffer.sv
// Elastic output buffer behind the FFT sample memory: a circular RAM plus one output
// holding register, with last-bin tagging, upstream backpressure and sticky overflow.
module fft_out_buffer #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_push,
  input  logic [31:0]   in_data,
  output logic          up_stall_F,
  output logic          out_push_F,
  output logic [15:0]   out_real_F,
  output logic [15:0]   out_imag_F,
  output logic          out_last_F,
  input  logic          out_stall,
  output logic          overflow_F,
  output logic [AW:0]   level_F
);

  localparam int unsigned BW        = $clog2(FRAME_LEN);
  localparam int unsigned RAM_WORDS = DEPTH - 1;
  localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STALL_LEVEL = (AW+1)'(DEPTH - FRAME_LEN);
  localparam logic [AW-1:0] LAST_PTR    = AW'(RAM_WORDS - 1);
  localparam logic [BW-1:0] LAST_BIN    = BW'(FRAME_LEN - 1);

  logic [32:0]   ram [RAM_WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] bin;
  logic [AW:0]   ram_count, level_next;
  logic          xfer, full, accept, load, ram_empty, ram_read, ram_write;
  logic [32:0]   in_word, ram_word;

  always_comb begin
    xfer      = out_push_F & ~out_stall;
    full      = (level_F == FULL_LEVEL);
    accept    = in_push & (~full | xfer);
    load      = ~out_push_F | xfer;
    ram_count = level_F - {{AW{1'b0}}, out_push_F};
    ram_empty = (ram_count == '0);
    ram_read  = load & ~ram_empty;
    // An accepted word goes to RAM unless it bypasses straight into an empty output register.
    ram_write = accept & ~(load & ram_empty);
    in_word   = {bin == LAST_BIN, in_data};
    ram_word  = ram[rd_ptr];
    level_next = level_F;
    if (accept & ~xfer)
      level_next = level_F + (AW+1)'(1);
    else if (xfer & ~accept)
      level_next = level_F - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bin        <= '0;
      out_push_F <= 1'b0;
      out_real_F <= '0;
      out_imag_F <= '0;
      out_last_F <= 1'b0;
      overflow_F <= 1'b0;
      level_F    <= '0;
      up_stall_F <= 1'b0;
    end else begin
      if (ram_write)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (ram_read)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      if (accept)
        bin <= (bin == LAST_BIN) ? '0 : bin + BW'(1);
      if (load) begin
        if (ram_read) begin
          {out_last_F, out_real_F, out_imag_F} <= ram_word;
          out_push_F <= 1'b1;
        end else if (accept) begin
          {out_last_F, out_real_F, out_imag_F} <= in_word;
          out_push_F <= 1'b1;
        end else begin
          out_push_F <= 1'b0;
        end
      end
      if (in_push & ~accept)
        overflow_F <= 1'b1;
      level_F    <= level_next;
      up_stall_F <= (level_next > STALL_LEVEL);
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (ram_write)
      ram[wr_ptr] <= in_word;
  end

endmodule
